// File: rtl/booth_acc_if.sv
// Handshake/data bundle between a product source, booth_acc and the result sink.
// master = source/sink side, slave = booth_acc.
interface booth_acc_if #(
    parameter int MUL_OUT_W = 16,
    parameter int ACC_W     = 24,
    parameter int LEN_W     = 8
);
    logic                        start;
    logic [LEN_W-1:0]            len;
    logic                        prod_valid;
    logic signed [MUL_OUT_W-1:0] prod;
    logic                        busy;
    logic                        acc_valid;
    logic                        acc_ready;
    logic signed [ACC_W-1:0]     acc_out;
    logic                        ovf;
    logic                        drop;

    modport master (
        output start, len, prod_valid, prod, acc_ready,
        input  busy, acc_valid, acc_out, ovf, drop
    );

    modport slave (
        input  start, len, prod_valid, prod, acc_ready,
        output busy, acc_valid, acc_out, ovf, drop
    );
endinterface

// File: rtl/booth_acc.sv
// Dot-product accumulator: sums a programmed run of signed products and offers the result on valid/ready.
// Optional macro BOOTH_ACC_SAT_EN: saturate on overflow instead of two's-complement wrap.
module booth_acc #(
    parameter int MUL_OUT_W = 16,
    parameter int ACC_W     = 24,
    parameter int LEN_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    booth_acc_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t                  state_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic [LEN_W-1:0]        count_reg;
    logic signed [ACC_W-1:0] acc_out_reg;
    logic                    acc_valid_reg;
    logic                    ovf_reg;
    logic                    drop_reg;
    logic                    busy_reg;

    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum_raw;
    logic signed [ACC_W-1:0] sum_next;
    logic                    add_ovf;

    always_comb begin
        prod_ext = {ACC_W{bus.prod[MUL_OUT_W-1]}};
        prod_ext[MUL_OUT_W-1:0] = bus.prod;
    end

    assign sum_raw = acc_reg + prod_ext;
    // Overflow only possible when both operands share a sign and the sum flips it.
    assign add_ovf = (acc_reg[ACC_W-1] == prod_ext[ACC_W-1]) &&
                     (sum_raw[ACC_W-1] != acc_reg[ACC_W-1]);

`ifdef BOOTH_ACC_SAT_EN
    always_comb begin
        sum_next = sum_raw;
        if (add_ovf) begin
            sum_next = {acc_reg[ACC_W-1], {(ACC_W-1){~acc_reg[ACC_W-1]}}};
        end
    end
`else
    assign sum_next = sum_raw;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            count_reg     <= '0;
            acc_out_reg   <= '0;
            acc_valid_reg <= 1'b0;
            ovf_reg       <= 1'b0;
            drop_reg      <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            // Products are only consumed in ACCUM; anything else is flagged and discarded.
            drop_reg <= bus.prod_valid && (state_reg != ACCUM);
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        acc_reg   <= '0;
                        ovf_reg   <= 1'b0;
                        count_reg <= bus.len;
                        busy_reg  <= 1'b1;
                        if (bus.len != '0) begin
                            state_reg <= ACCUM;
                        end else begin
                            state_reg     <= HOLD;
                            acc_out_reg   <= '0;
                            acc_valid_reg <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (bus.prod_valid) begin
                        acc_reg   <= sum_next;
                        ovf_reg   <= ovf_reg | add_ovf;
                        count_reg <= count_reg - LEN_W'(1);
                        if (count_reg == LEN_W'(1)) begin
                            state_reg     <= HOLD;
                            acc_out_reg   <= sum_next;
                            acc_valid_reg <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.acc_ready) begin
                        state_reg     <= IDLE;
                        acc_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.acc_valid = acc_valid_reg;
    assign bus.acc_out   = acc_out_reg;
    assign bus.ovf       = ovf_reg;
    assign bus.drop      = drop_reg;
endmodule

// File: tb/tb_booth_acc.sv
// Directed bench for booth_acc: a 24-bit accumulator instance plus a 16-bit one for overflow cases.
module tb_booth_acc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    booth_acc_if #(.MUL_OUT_W(16), .ACC_W(24), .LEN_W(8)) m ();
    booth_acc_if #(.MUL_OUT_W(16), .ACC_W(16), .LEN_W(8)) n ();

    booth_acc #(.MUL_OUT_W(16), .ACC_W(24), .LEN_W(8)) u_acc24 (
        .clk(clk), .rst_n(rst_n), .bus(m.slave)
    );
    booth_acc #(.MUL_OUT_W(16), .ACC_W(16), .LEN_W(8)) u_acc16 (
        .clk(clk), .rst_n(rst_n), .bus(n.slave)
    );

    // Stimulus helpers: called on a falling edge, return on the next falling edge.
    task automatic do_start(input int l);
        m.start = 1'b1; m.len = 8'(l);
        @(negedge clk);
        m.start = 1'b0;
    endtask

    task automatic do_prod(input int p);
        m.prod_valid = 1'b1; m.prod = 16'(p);
        @(negedge clk);
        m.prod_valid = 1'b0;
    endtask

    task automatic do_ack();
        m.acc_ready = 1'b1;
        @(negedge clk);
        m.acc_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (m.busy !== 1'b0 || m.acc_valid !== 1'b0 || m.ovf !== 1'b0 || m.drop !== 1'b0) begin
            bad++; $display("FAIL reset_flags got=%b%b%b%b want=0000", m.busy, m.acc_valid, m.ovf, m.drop); end
        total++; if (m.acc_out !== 24'sd0) begin bad++; $display("FAIL reset_acc_out got=%0d want=0", m.acc_out); end
        total++; if (n.acc_valid !== 1'b0 || n.acc_out !== 16'sd0) begin
            bad++; $display("FAIL reset_acc16 got=%b/%0d want=0/0", n.acc_valid, n.acc_out); end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_basic();
        do_start(3);
        total++; if (m.busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", m.busy); end
        do_prod(100); repeat (3) @(negedge clk);
        do_prod(-50); repeat (3) @(negedge clk);
        total++; if (m.acc_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b want=0", m.acc_valid); end
        do_prod(7);
        total++; if (m.acc_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", m.acc_valid); end
        total++; if (m.acc_out !== 24'sd57) begin bad++; $display("FAIL basic_acc got=%0d want=57", m.acc_out); end
        total++; if (m.ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b want=0", m.ovf); end
        do_ack();
        total++; if (m.acc_valid !== 1'b0 || m.busy !== 1'b0) begin
            bad++; $display("FAIL basic_after_ack got=%b%b want=00", m.acc_valid, m.busy); end
        $display("run len=3 result=%0d", m.acc_out);
    endtask

    task automatic test_len_zero();
        do_start(0);
        total++; if (m.acc_valid !== 1'b1 || m.acc_out !== 24'sd0) begin
            bad++; $display("FAIL len0_result got=%b/%0d want=1/0", m.acc_valid, m.acc_out); end
        do_ack();
        total++; if (m.busy !== 1'b0 || m.acc_valid !== 1'b0) begin
            bad++; $display("FAIL len0_idle got=%b%b want=00", m.busy, m.acc_valid); end
        $display("run len=0 result=0");
    endtask

    task automatic test_overflow();
        int want;
`ifdef BOOTH_ACC_SAT_EN
        want = 32767;
`else
        want = -16384;
`endif
        n.start = 1'b1; n.len = 8'd3;
        @(negedge clk);
        n.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n.prod_valid = 1'b1; n.prod = 16'sd16384;
            @(negedge clk);
            n.prod_valid = 1'b0;
        end
        total++; if (n.acc_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid got=%b want=1", n.acc_valid); end
        total++; if (n.acc_out !== 16'(want)) begin bad++; $display("FAIL ovf_acc got=%0d want=%0d", n.acc_out, want); end
        total++; if (n.ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", n.ovf); end
        n.acc_ready = 1'b1;
        @(negedge clk);
        n.acc_ready = 1'b0;
        $display("run acc16 len=3 result=%0d ovf=%b", n.acc_out, n.ovf);
    endtask

    task automatic test_hold_stall();
        do_start(2); do_prod(5); do_prod(6);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin m.start = 1'b1; m.len = 8'd1; end
            @(negedge clk);
            m.start = 1'b0;
            total++; if (m.acc_valid !== 1'b1 || m.acc_out !== 24'sd11 || m.busy !== 1'b1) begin
                bad++; $display("FAIL stall_cycle%0d got=%b/%0d/%b want=1/11/1", i, m.acc_valid, m.acc_out, m.busy); end
        end
        // Handshake and start in the same cycle: the start must be ignored.
        m.acc_ready = 1'b1; m.start = 1'b1; m.len = 8'd1;
        @(negedge clk);
        m.acc_ready = 1'b0; m.start = 1'b0;
        total++; if (m.acc_valid !== 1'b0 || m.busy !== 1'b0) begin
            bad++; $display("FAIL stall_handshake got=%b%b want=00", m.acc_valid, m.busy); end
        $display("run len=2 stalled result=11");
    endtask

    task automatic test_drop();
        do_prod(99);
        total++; if (m.drop !== 1'b1) begin bad++; $display("FAIL drop_idle got=%b want=1", m.drop); end
        @(negedge clk);
        total++; if (m.drop !== 1'b0) begin bad++; $display("FAIL drop_pulse got=%b want=0", m.drop); end
        do_start(1); do_prod(4);
        total++; if (m.drop !== 1'b0) begin bad++; $display("FAIL drop_accum got=%b want=0", m.drop); end
        do_prod(1000);
        total++; if (m.drop !== 1'b1 || m.acc_out !== 24'sd4 || m.acc_valid !== 1'b1) begin
            bad++; $display("FAIL drop_hold got=%b/%0d/%b want=1/4/1", m.drop, m.acc_out, m.acc_valid); end
        do_ack();
        m.start = 1'b1; m.len = 8'd1; m.prod_valid = 1'b1; m.prod = 16'sd50;
        @(negedge clk);
        m.start = 1'b0; m.prod_valid = 1'b0;
        total++; if (m.drop !== 1'b1 || m.busy !== 1'b1) begin
            bad++; $display("FAIL drop_with_start got=%b%b want=11", m.drop, m.busy); end
        do_prod(3);
        total++; if (m.acc_out !== 24'sd3 || m.acc_valid !== 1'b1) begin
            bad++; $display("FAIL drop_start_result got=%0d/%b want=3/1", m.acc_out, m.acc_valid); end
        do_ack();
        $display("drop checks result=%0d", m.acc_out);
    endtask

    task automatic test_async_abort();
        do_start(4); do_prod(10);
        #2 rst_n = 1'b0;
        #1;
        total++; if (m.busy !== 1'b0 || m.acc_valid !== 1'b0 || m.ovf !== 1'b0 || m.acc_out !== 24'sd0) begin
            bad++; $display("FAIL abort_clear got=%b%b%b/%0d want=000/0", m.busy, m.acc_valid, m.ovf, m.acc_out); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (m.acc_valid !== 1'b0) begin bad++; $display("FAIL abort_no_result got=%b want=0", m.acc_valid); end
        do_start(1); do_prod(-5);
        total++; if (m.acc_out !== -24'sd5 || m.acc_valid !== 1'b1) begin
            bad++; $display("FAIL abort_rerun got=%0d/%b want=-5/1", m.acc_out, m.acc_valid); end
        do_ack();
        $display("run after abort len=1 result=%0d", m.acc_out);
    endtask

    task automatic test_dot_product();
        int a [4] = '{3, -7, 12, -128};
        int b [4] = '{-5, 9, 127, -128};
        int want = 0;
        do_start(4);
        for (int i = 0; i < 4; i++) begin
            want += a[i] * b[i];
            do_prod(a[i] * b[i]);
            repeat (i) @(negedge clk);
        end
        total++; if (m.acc_out !== 24'(want) || want != 17830) begin
            bad++; $display("FAIL dot_acc got=%0d want=%0d", m.acc_out, want); end
        total++; if (m.acc_valid !== 1'b1 || m.ovf !== 1'b0) begin
            bad++; $display("FAIL dot_flags got=%b%b want=10", m.acc_valid, m.ovf); end
        do_ack();
        $display("run dot len=4 result=%0d", m.acc_out);
    endtask

    initial begin
        m.start = 1'b0; m.len = '0; m.prod_valid = 1'b0; m.prod = '0; m.acc_ready = 1'b0;
        n.start = 1'b0; n.len = '0; n.prod_valid = 1'b0; n.prod = '0; n.acc_ready = 1'b0;
        test_reset();
        test_basic();
        test_len_zero();
        test_overflow();
        test_hold_stall();
        test_drop();
        test_async_abort();
        test_dot_product();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
